// File: rtl/rv_structs.sv
// Shared types for the branch-resolve slice: resolver FSM states and funct3 branch codes.
package rv_structs;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } br_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv_branch_cmp.sv
// Combinational branch-condition evaluator; reserved funct3 codes resolve not-taken.
module rv_branch_cmp
  import rv_structs::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_cond
);

  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_cond = (i_op1 == i_op2);
      F3_BNE:  o_cond = (i_op1 != i_op2);
      F3_BLT:  o_cond = ($signed(i_op1) <  $signed(i_op2));
      F3_BGE:  o_cond = ($signed(i_op1) >= $signed(i_op2));
      F3_BLTU: o_cond = (i_op1 <  i_op2);
      F3_BGEU: o_cond = (i_op1 >= i_op2);
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_branch_resolve.sv
// Branch resolver: captures a control-flow instruction, checks the prediction and issues a fetch redirect.
// Optional macro RV_BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module rv_branch_resolve
  import rv_structs::*;
#(
  parameter int IADDR_SPACE_BITS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_stall,
  input  logic                        i_inst_jal_jalr,
  input  logic                        i_inst_branch,
  input  logic [2:0]                  i_funct3,
  input  logic [31:0]                 i_op1,
  input  logic [31:0]                 i_op2,
  input  logic [IADDR_SPACE_BITS-1:1] i_pc_next,
  input  logic [IADDR_SPACE_BITS-1:1] i_pc_seq,
  input  logic [IADDR_SPACE_BITS-1:1] i_pc_target,
  input  logic                        i_to_trap,
  input  logic                        i_redirect_ready,
  output logic                        o_redirect_valid,
  output logic [IADDR_SPACE_BITS-1:1] o_redirect_pc,
  output logic                        o_flush,
  output logic                        o_stall
`ifdef RV_BRANCH_STATS_EN
  ,
  output logic [31:0]                 o_branch_cnt,
  output logic [31:0]                 o_mispred_cnt
`endif
);

  br_state_e                   state_q, state_d;
  logic                        flush_q, flush_d;
  logic [IADDR_SPACE_BITS-1:1] rpc_q, rpc_d;

  logic                        jal_q, br_q, trap_q;
  logic [2:0]                  f3_q;
  logic [31:0]                 op1_q, op2_q;
  logic [IADDR_SPACE_BITS-1:1] pcn_q, pcs_q, pct_q;

  logic                        cond, taken, mispredict, capture, slot_clr;
  logic [IADDR_SPACE_BITS-1:1] actual;

  rv_branch_cmp u_cmp (
    .i_funct3 (f3_q),
    .i_op1    (op1_q),
    .i_op2    (op2_q),
    .o_cond   (cond)
  );

  assign taken      = jal_q | (br_q & cond);
  assign actual     = taken ? pct_q : pcs_q;
  assign mispredict = (jal_q | br_q) & ~trap_q & (actual != pcn_q);
  assign capture    = (state_q == ST_IDLE) & ~i_stall;
  assign slot_clr   = i_flush | (state_q == ST_REDIRECT);

  // Valid bits: clearing wins over capture so a flushed/redirected slot never resolves.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      jal_q  <= 1'b0;
      br_q   <= 1'b0;
      trap_q <= 1'b0;
    end else if (slot_clr) begin
      jal_q  <= 1'b0;
      br_q   <= 1'b0;
      trap_q <= 1'b0;
    end else if (capture) begin
      jal_q  <= i_inst_jal_jalr;
      br_q   <= i_inst_branch;
      trap_q <= i_to_trap;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      f3_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
      pcn_q <= '0;
      pcs_q <= '0;
      pct_q <= '0;
    end else if (capture) begin
      f3_q  <= i_funct3;
      op1_q <= i_op1;
      op2_q <= i_op2;
      pcn_q <= i_pc_next;
      pcs_q <= i_pc_seq;
      pct_q <= i_pc_target;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    rpc_d   = rpc_q;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (mispredict) begin
          state_d = ST_REDIRECT;
          flush_d = 1'b1;
          rpc_d   = actual;
        end
        ST_REDIRECT: if (i_redirect_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      rpc_q   <= rpc_d;
    end
  end

  assign o_redirect_valid = (state_q == ST_REDIRECT);
  assign o_stall          = (state_q == ST_REDIRECT);
  assign o_flush          = flush_q;
  assign o_redirect_pc    = rpc_q;

`ifdef RV_BRANCH_STATS_EN
  logic [31:0] bcnt_q, mcnt_q;
  logic        resolve;

  // A held (stalled) slot is counted once, when it is replaced or triggers a redirect.
  assign resolve = (state_q == ST_IDLE) & (jal_q | br_q) & ~trap_q & ~i_flush
                 & (~i_stall | mispredict);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (resolve) begin
      bcnt_q <= bcnt_q + 32'd1;
      if (mispredict) mcnt_q <= mcnt_q + 32'd1;
    end
  end

  assign o_branch_cnt  = bcnt_q;
  assign o_mispred_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_rv_branch_resolve.sv
// Bench for rv_branch_resolve: vector table with a redirect scoreboard plus hand-written corner sequences.
module tb_rv_branch_resolve;

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_flush, i_stall, i_jal, i_br, i_trap, i_ready;
  logic [2:0]  i_f3;
  logic [31:0] i_op1, i_op2;
  logic [31:1] i_pcn, i_pcs, i_pct;
  logic        o_valid, o_flush, o_stall;
  logic [31:1] o_pc;
`ifdef RV_BRANCH_STATS_EN
  logic [31:0] o_bcnt, o_mcnt;
`endif

  rv_branch_resolve #(.IADDR_SPACE_BITS(32)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_flush          (i_flush),
    .i_stall          (i_stall),
    .i_inst_jal_jalr  (i_jal),
    .i_inst_branch    (i_br),
    .i_funct3         (i_f3),
    .i_op1            (i_op1),
    .i_op2            (i_op2),
    .i_pc_next        (i_pcn),
    .i_pc_seq         (i_pcs),
    .i_pc_target      (i_pct),
    .i_to_trap        (i_trap),
    .i_redirect_ready (i_ready),
    .o_redirect_valid (o_valid),
    .o_redirect_pc    (o_pc),
    .o_flush          (o_flush),
    .o_stall          (o_stall)
`ifdef RV_BRANCH_STATS_EN
    ,
    .o_branch_cnt     (o_bcnt),
    .o_mispred_cnt    (o_mcnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        jal, br;
    logic [2:0]  f3;
    logic [31:0] op1, op2;
    logic [30:0] pcn, pcs, pct;
    logic        trap;
    logic        exp_redir;
    logic [30:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        redir;
    logic [30:0] pc;
  } exp_t;

  vec_t vecs[14];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_jal = 1'b0; i_br = 1'b0; i_trap = 1'b0; i_f3 = 3'b000;
    i_op1 = '0; i_op2 = '0; i_pcn = '0; i_pcs = '0; i_pct = '0;
  endtask

  task automatic drive(input vec_t v);
    i_jal = v.jal; i_br = v.br; i_f3 = v.f3; i_op1 = v.op1; i_op2 = v.op2;
    i_pcn = v.pcn; i_pcs = v.pcs; i_pct = v.pct; i_trap = v.trap;
  endtask

  // Capture at edge N, outcome sampled after edge N+1, exit (ready=1) after edge N+2.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge i_clk);
    i_ready = 1'b1;
    drive(v);
    exp_q.push_back('{redir: v.exp_redir, pc: v.exp_pc});
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    if (exp_q.size() == 0) chk($sformatf("v%0d.sb_underflow", idx), 64'(1), 64'(0));
    else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d.valid", idx), 64'(o_valid), 64'(e.redir));
      chk($sformatf("v%0d.flush", idx), 64'(o_flush), 64'(e.redir));
      chk($sformatf("v%0d.stall", idx), 64'(o_stall), 64'(e.redir));
      if (e.redir) chk($sformatf("v%0d.pc", idx), 64'(o_pc), 64'(e.pc));
    end
    @(negedge i_clk);
    chk($sformatf("v%0d.done", idx), 64'({o_valid, o_flush, o_stall}), 64'(0));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 31'h0, 31'h82, 31'h200, 1'b0, 1'b1, 31'h200};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'd5, 32'd6, 31'h82, 31'h82, 31'h200, 1'b0, 1'b0, 31'h0};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'd5, 32'd6, 31'h82, 31'h82, 31'h300, 1'b0, 1'b1, 31'h300};
    vecs[3]  = '{1'b0, 1'b1, 3'b100, 32'hFFFFFFFF, 32'd1, 31'h82, 31'h82, 31'h400, 1'b0, 1'b1, 31'h400};
    vecs[4]  = '{1'b0, 1'b1, 3'b110, 32'hFFFFFFFF, 32'd1, 31'h82, 31'h82, 31'h400, 1'b0, 1'b0, 31'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'b101, 32'hFFFFFFFF, 32'd1, 31'h82, 31'h82, 31'h410, 1'b0, 1'b0, 31'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'b111, 32'hFFFFFFFF, 32'd1, 31'h82, 31'h82, 31'h410, 1'b0, 1'b1, 31'h410};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'd5, 32'd5, 31'h82, 31'h82, 31'h500, 1'b0, 1'b0, 31'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b011, 32'd5, 32'd5, 31'h500, 31'h82, 31'h500, 1'b0, 1'b1, 31'h82};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 31'h600, 31'h82, 31'h600, 1'b0, 1'b0, 31'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 31'h82, 31'h82, 31'h600, 1'b0, 1'b1, 31'h600};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'd5, 32'd5, 31'h0, 31'h82, 31'h200, 1'b1, 1'b0, 31'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h80000000, 32'h7FFFFFFF, 31'h700, 31'h82, 31'h700, 1'b0, 1'b0, 31'h0};
    vecs[13] = '{1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 31'h123, 31'h82, 31'h200, 1'b0, 1'b0, 31'h0};

    i_reset_n = 1'b0; i_flush = 1'b0; i_stall = 1'b0; i_ready = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    chk("reset.outs", 64'({o_valid, o_flush, o_stall}), 64'(0));
    chk("reset.pc", 64'(o_pc), 64'(0));
    @(negedge i_clk);
    i_reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Ready held low for three REDIRECT cycles: four valid cycles, one flush pulse, stable PC.
    @(negedge i_clk);
    i_ready = 1'b0;
    drive(vecs[0]);
    @(negedge i_clk);
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge i_clk);
      chk($sformatf("hold.c%0d.valid", c), 64'(o_valid), 64'(1));
      chk($sformatf("hold.c%0d.stall", c), 64'(o_stall), 64'(1));
      chk($sformatf("hold.c%0d.pc", c), 64'(o_pc), 64'(31'h200));
      chk($sformatf("hold.c%0d.flush", c), 64'(o_flush), 64'(c == 1));
      if (c == 4) i_ready = 1'b1;
    end
    @(negedge i_clk);
    chk("hold.exit", 64'({o_valid, o_stall}), 64'(0));

    // Flush in the second REDIRECT cycle aborts the request.
    i_ready = 1'b0;
    drive(vecs[2]);
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    chk("fl.c1.valid", 64'(o_valid), 64'(1));
    @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    i_ready = 1'b1;
    chk("fl.abort", 64'({o_valid, o_flush, o_stall}), 64'(0));
    @(negedge i_clk);
    chk("fl.stay_idle", 64'(o_valid), 64'(0));

    // Flush on the resolve edge beats a captured mispredict.
    drive(vecs[0]);
    @(negedge i_clk);
    idle_inputs();
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("fl.prio", 64'({o_valid, o_flush}), 64'(0));

    // Stall at the capture edge: the instruction is never captured.
    drive(vecs[0]);
    i_stall = 1'b1;
    @(negedge i_clk);
    idle_inputs();
    i_stall = 1'b0;
    @(negedge i_clk);
    chk("stall.nocap", 64'(o_valid), 64'(0));
    @(negedge i_clk);
    chk("stall.nocap2", 64'(o_valid), 64'(0));

    // Asynchronous reset mid-REDIRECT drops the request immediately.
    i_ready = 1'b0;
    drive(vecs[3]);
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    chk("rst.pre_valid", 64'(o_valid), 64'(1));
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst.async_outs", 64'({o_valid, o_flush, o_stall}), 64'(0));
    chk("rst.async_pc", 64'(o_pc), 64'(0));
`ifdef RV_BRANCH_STATS_EN
    chk("rst.bcnt", 64'(o_bcnt), 64'(0));
    chk("rst.mcnt", 64'(o_mcnt), 64'(0));
`endif
    @(negedge i_clk);
    i_reset_n = 1'b1;
    i_ready = 1'b1;

`ifdef RV_BRANCH_STATS_EN
    for (int i = 0; i < 10; i++) run_vec(i < 3 ? vecs[0] : vecs[1], 100 + i);
    chk("stats.bcnt", 64'(o_bcnt), 64'(10));
    chk("stats.mcnt", 64'(o_mcnt), 64'(3));
`else
    for (int i = 0; i < 3; i++) run_vec(vecs[i], 100 + i);
`endif

    chk("sb.empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
